// File: rtl/cpm_bank_sched.sv
// Banked scratchpad scheduler: per-bank round-robin arbitration across requesters,
// registered SRAM command stage, and fixed-latency read return routing.
module cpm_bank_sched #(
  parameter int REQ_DW = 4,
  parameter int IDX_AW = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16,
  parameter int REQ_AW = $clog2(REQ_DW)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sched_en,
  input  logic [REQ_DW-1:0]                    req_vld,
  output logic [REQ_DW-1:0]                    req_rdy,
  input  logic [REQ_DW-1:0]                    req_we,
  input  logic [REQ_DW*(ADDR_W+IDX_AW)-1:0]    req_addr,
  input  logic [REQ_DW*DATA_W-1:0]             req_wdat,
  output logic [REQ_DW-1:0]                    rsp_vld,
  output logic [REQ_DW*DATA_W-1:0]             rsp_dat,
  output logic [(1<<IDX_AW)-1:0]               bank_en,
  output logic [(1<<IDX_AW)-1:0]               bank_we,
  output logic [(1<<IDX_AW)*ADDR_W-1:0]        bank_addr,
  output logic [(1<<IDX_AW)*DATA_W-1:0]        bank_wdat,
  input  logic [(1<<IDX_AW)*DATA_W-1:0]        bank_rdat,
  input  logic                                 cfg_clr,
  output logic [CNT_W-1:0]                     stall_cnt
);

  localparam int BANK_NUM = 1 << IDX_AW;
  localparam int AW       = ADDR_W + IDX_AW;
  localparam int TAG_N    = RD_LAT + 1;

  logic [IDX_AW-1:0] req_bank [REQ_DW];
  logic [ADDR_W-1:0] req_loc  [REQ_DW];
  logic [DATA_W-1:0] req_wd   [REQ_DW];

  logic [BANK_NUM-1:0] gnt_vld;
  logic [REQ_AW-1:0]   gnt_id      [BANK_NUM];
  logic [BANK_NUM-1:0] tag_out_vld;
  logic [REQ_AW-1:0]   tag_out_id  [BANK_NUM];
  logic [DATA_W-1:0]   bank_rd     [BANK_NUM];

  logic [CNT_W-1:0] stall_cnt_reg;
  logic             stall_any;

  genvar gi;

  generate
    for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
      logic [REQ_DW-1:0] cand;
      logic [REQ_AW-1:0] scan_idx;
      logic              win_vld;
      logic [REQ_AW-1:0] win_id;
      logic [REQ_AW-1:0] ptr_reg;
      logic              en_reg;
      logic              we_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] wdat_reg;
      logic [TAG_N-1:0]  tag_vld_reg;
      logic [REQ_AW-1:0] tag_id_reg [TAG_N];

      always_comb begin
        for (int i = 0; i < REQ_DW; i++)
          cand[i] = sched_en & req_vld[i] & (req_bank[i] == IDX_AW'(gi));
      end

      // First candidate at or after the pointer wins; the id wraps naturally.
      always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int k = 0; k < REQ_DW; k++) begin
          scan_idx = ptr_reg + REQ_AW'(k);
          if (!win_vld && cand[scan_idx]) begin
            win_vld = 1'b1;
            win_id  = scan_idx;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_reg     <= '0;
          en_reg      <= 1'b0;
          we_reg      <= 1'b0;
          addr_reg    <= '0;
          wdat_reg    <= '0;
          tag_vld_reg <= '0;
          for (int s = 0; s < TAG_N; s++) tag_id_reg[s] <= '0;
        end else begin
          en_reg         <= win_vld;
          we_reg         <= win_vld & req_we[win_id];
          tag_vld_reg[0] <= win_vld & ~req_we[win_id];
          tag_id_reg[0]  <= win_id;
          for (int s = 1; s < TAG_N; s++) begin
            tag_vld_reg[s] <= tag_vld_reg[s-1];
            tag_id_reg[s]  <= tag_id_reg[s-1];
          end
          if (win_vld) begin
            ptr_reg  <= win_id + REQ_AW'(1);
            addr_reg <= req_loc[win_id];
            wdat_reg <= req_wd[win_id];
          end
        end
      end

      assign gnt_vld[gi]                    = win_vld;
      assign gnt_id[gi]                     = win_id;
      assign bank_en[gi]                    = en_reg;
      assign bank_we[gi]                    = we_reg;
      assign bank_addr[gi*ADDR_W +: ADDR_W] = addr_reg;
      assign bank_wdat[gi*DATA_W +: DATA_W] = wdat_reg;
      assign tag_out_vld[gi]                = tag_vld_reg[TAG_N-1];
      assign tag_out_id[gi]                 = tag_id_reg[TAG_N-1];
      assign bank_rd[gi]                    = bank_rdat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  generate
    for (gi = 0; gi < REQ_DW; gi++) begin : g_req
      logic              hit;
      logic [DATA_W-1:0] sel;
      logic              vld_reg;
      logic [DATA_W-1:0] dat_reg;

      assign req_bank[gi] = req_addr[gi*AW +: IDX_AW];
      assign req_loc[gi]  = req_addr[gi*AW+IDX_AW +: ADDR_W];
      assign req_wd[gi]   = req_wdat[gi*DATA_W +: DATA_W];

      // A requester is ready only when it is the winner of the bank it targets.
      assign req_rdy[gi] = gnt_vld[req_bank[gi]] & (gnt_id[req_bank[gi]] == REQ_AW'(gi));

      always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
          if (tag_out_vld[b] && tag_out_id[b] == REQ_AW'(gi)) begin
            hit = 1'b1;
            sel = bank_rd[b];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg <= 1'b0;
          dat_reg <= '0;
        end else begin
          vld_reg <= hit;
          if (hit) dat_reg <= sel;
        end
      end

      assign rsp_vld[gi]                  = vld_reg;
      assign rsp_dat[gi*DATA_W +: DATA_W] = dat_reg;
    end
  endgenerate

  assign stall_any = |(req_vld & ~req_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (cfg_clr) begin
      stall_cnt_reg <= '0;
    end else if (stall_any && stall_cnt_reg != {CNT_W{1'b1}}) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_cpm_bank_sched.sv
// Scoreboard bench for cpm_bank_sched: directed scenarios plus random traffic against
// a behavioural bank/round-robin model, with a synchronous SRAM model on the bank side.
`timescale 1ns/1ps
module tb_cpm_bank_sched;
  localparam int REQ_DW   = 4;
  localparam int IDX_AW   = 2;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 1;
  localparam int CNT_W    = 5;
  localparam int BANK_NUM = 4;
  localparam int AW       = ADDR_W + IDX_AW;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sched_en = 1'b0;
  logic cfg_clr = 1'b0;
  logic [REQ_DW-1:0] req_vld = '0, req_we = '0;
  logic [REQ_DW-1:0] req_rdy, rsp_vld;
  logic [REQ_DW*AW-1:0] req_addr = '0;
  logic [REQ_DW*DATA_W-1:0] req_wdat = '0;
  logic [REQ_DW*DATA_W-1:0] rsp_dat;
  logic [BANK_NUM-1:0] bank_en, bank_we;
  logic [BANK_NUM*ADDR_W-1:0] bank_addr;
  logic [BANK_NUM*DATA_W-1:0] bank_wdat, bank_rdat;
  logic [CNT_W-1:0] stall_cnt;

  cpm_bank_sched #(
    .REQ_DW(REQ_DW), .IDX_AW(IDX_AW), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdat(req_wdat),
    .rsp_vld(rsp_vld), .rsp_dat(rsp_dat),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdat(bank_wdat), .bank_rdat(bank_rdat),
    .cfg_clr(cfg_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_val(int b, int a);
    if (b == 2 && a == 5) return 16'hABCD;
    return DATA_W'((b * 1031 + a * 77) ^ 16'h5A5A);
  endfunction

  // Bank SRAMs: one-cycle synchronous read.
  logic [DATA_W-1:0] sram [BANK_NUM][DEPTH];
  logic [DATA_W-1:0] rdat_q [BANK_NUM];
  always @(posedge clk) begin
    for (int b = 0; b < BANK_NUM; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) sram[b][bank_addr[b*ADDR_W +: ADDR_W]] <= bank_wdat[b*DATA_W +: DATA_W];
        else rdat_q[b] <= sram[b][bank_addr[b*ADDR_W +: ADDR_W]];
      end
    end
  end
  always_comb begin
    bank_rdat = '0;
    for (int b = 0; b < BANK_NUM; b++) bank_rdat[b*DATA_W +: DATA_W] = rdat_q[b];
  end

  // Reference model state and scoreboard queues.
  typedef struct { int due; logic [DATA_W-1:0] dat; } rsp_t;
  typedef struct { int due; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdat; } cmd_t;
  rsp_t rsp_q [REQ_DW][$];
  cmd_t cmd_q [BANK_NUM][$];
  logic [DATA_W-1:0] ref_mem [BANK_NUM][DEPTH];
  int ref_ptr [BANK_NUM];
  int exp_stall = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor/model: compares outputs, then applies this cycle's grants to the model.
  always @(negedge clk) begin : model
    logic exp_due;
    logic [REQ_DW-1:0] exp_rdy;
    int g, i, la;
    cmd_t c;
    if (!rst_n) begin
      for (int b = 0; b < BANK_NUM; b++) begin cmd_q[b].delete(); ref_ptr[b] = 0; end
      for (int r = 0; r < REQ_DW; r++) rsp_q[r].delete();
      exp_stall = 0;
      chk("rst_bank_en", bank_en, 0);
      chk("rst_bank_we", bank_we, 0);
      chk("rst_bank_addr", bank_addr, 0);
      chk("rst_bank_wdat", bank_wdat, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_rsp_dat", rsp_dat, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_req_rdy", req_rdy, 0);
    end else begin
      for (int r = 0; r < REQ_DW; r++) begin
        exp_due = rsp_q[r].size() > 0 && rsp_q[r][0].due == cyc;
        chk($sformatf("rsp_vld[%0d]", r), rsp_vld[r], exp_due);
        if (exp_due) begin
          if (rsp_vld[r]) chk($sformatf("rsp_dat[%0d]", r), rsp_dat[r*DATA_W +: DATA_W], rsp_q[r][0].dat);
          rsp_q[r].delete(0);
        end
      end
      for (int b = 0; b < BANK_NUM; b++) begin
        exp_due = cmd_q[b].size() > 0 && cmd_q[b][0].due == cyc;
        chk($sformatf("bank_en[%0d]", b), bank_en[b], exp_due);
        if (exp_due) begin
          c = cmd_q[b][0];
          if (bank_en[b]) begin
            chk($sformatf("bank_we[%0d]", b), bank_we[b], c.we);
            chk($sformatf("bank_addr[%0d]", b), bank_addr[b*ADDR_W +: ADDR_W], c.addr);
            if (c.we) chk($sformatf("bank_wdat[%0d]", b), bank_wdat[b*DATA_W +: DATA_W], c.wdat);
          end
          cmd_q[b].delete(0);
        end
      end
      chk("stall_cnt", stall_cnt, exp_stall);

      exp_rdy = '0;
      for (int b = 0; b < BANK_NUM; b++) begin
        g = -1;
        for (int k = 0; k < REQ_DW; k++) begin
          i = (ref_ptr[b] + k) % REQ_DW;
          if (g < 0 && sched_en && req_vld[i] && int'(req_addr[i*AW +: IDX_AW]) == b) g = i;
        end
        if (g >= 0) begin
          exp_rdy[g] = 1'b1;
          ref_ptr[b] = (g + 1) % REQ_DW;
          la = int'(req_addr[g*AW+IDX_AW +: ADDR_W]);
          cmd_q[b].push_back('{cyc + 1, req_we[g], ADDR_W'(la), req_wdat[g*DATA_W +: DATA_W]});
          if (req_we[g]) ref_mem[b][la] = req_wdat[g*DATA_W +: DATA_W];
          else rsp_q[g].push_back('{cyc + 2 + RD_LAT, ref_mem[b][la]});
          $display("txn cyc=%0d req=%0d bank=%0d %s addr=%0h data=%0h", cyc, g, b,
                   req_we[g] ? "wr" : "rd", la, ref_mem[b][la]);
        end
      end
      chk("req_rdy", req_rdy, exp_rdy);
      if (cfg_clr) exp_stall = 0;
      else if (|(req_vld & ~exp_rdy) && exp_stall < (1 << CNT_W) - 1) exp_stall++;
    end
  end

  // Requester-side driver state.
  logic [REQ_DW-1:0] pend_vld = '0, pend_we = '0;
  int pend_bank [REQ_DW];
  int pend_addr [REQ_DW];
  logic [DATA_W-1:0] pend_wdat [REQ_DW];
  bit gen_en = 1'b0;
  logic drv_sched = 1'b0, drv_clr = 1'b0;

  task automatic set_req(input int r, input bit we, input int b, input int a, input logic [DATA_W-1:0] d);
    pend_vld[r] = 1'b1; pend_we[r] = we; pend_bank[r] = b; pend_addr[r] = a; pend_wdat[r] = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (gen_en)
      for (int r = 0; r < REQ_DW; r++)
        if (!pend_vld[r] && ($urandom % 2) == 1)
          set_req(r, ($urandom % 3) == 0, int'($urandom % BANK_NUM), int'($urandom % 16), DATA_W'($urandom));
    sched_en = drv_sched;
    cfg_clr  = drv_clr;
    for (int r = 0; r < REQ_DW; r++) begin
      req_vld[r] = pend_vld[r];
      req_we[r]  = pend_we[r];
      req_addr[r*AW +: AW] = {ADDR_W'(pend_addr[r]), IDX_AW'(pend_bank[r])};
      req_wdat[r*DATA_W +: DATA_W] = pend_wdat[r];
    end
    @(negedge clk);
    pend_vld = pend_vld & ~(req_vld & req_rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int b = 0; b < BANK_NUM; b++)
      for (int a = 0; a < DEPTH; a++) begin
        sram[b][a] = init_val(b, a);
        ref_mem[b][a] = init_val(b, a);
      end
    for (int b = 0; b < BANK_NUM; b++) rdat_q[b] = '0;
    for (int r = 0; r < REQ_DW; r++) begin pend_bank[r] = 0; pend_addr[r] = 0; pend_wdat[r] = '0; end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drv_sched = 1'b1;

    // Single read: req 1 -> bank 2 addr 5, data 0xABCD.
    set_req(1, 1'b0, 2, 5, '0);
    repeat (6) step();
    chk("single_read_done", pend_vld, 0);

    // Four readers on bank 0: grants 0,1,2,3 in successive cycles.
    for (int r = 0; r < REQ_DW; r++) set_req(r, 1'b0, 0, r + 8, '0);
    repeat (8) step();
    chk("bank0_contention_done", pend_vld, 0);

    // Four readers on four banks: all granted together.
    for (int r = 0; r < REQ_DW; r++) set_req(r, 1'b0, r, r + 32, '0);
    repeat (5) step();
    chk("parallel_done", pend_vld, 0);

    // Bank 1: req 2 alone, then reqs 0 and 3 contend.
    set_req(2, 1'b0, 1, 3, '0);
    step();
    set_req(0, 1'b0, 1, 4, '0);
    set_req(3, 1'b0, 1, 5, '0);
    repeat (6) step();
    chk("rr_bank1_done", pend_vld, 0);

    // Write then read-back on bank 3.
    set_req(0, 1'b1, 3, 42, 16'h1234);
    step();
    set_req(3, 1'b0, 3, 42, '0);
    repeat (6) step();
    chk("wr_rd_done", pend_vld, 0);

    // Scheduler off with requests held: counter saturates, then clear wins.
    drv_sched = 1'b0;
    for (int r = 0; r < REQ_DW; r++) set_req(r, 1'b0, r % 2, r, '0);
    repeat (40) step();
    drv_clr = 1'b1;
    step();
    drv_clr = 1'b0;
    drv_sched = 1'b1;
    repeat (6) step();
    chk("sat_drain_done", pend_vld, 0);

    // Reset one cycle after a read is accepted: the response must never appear.
    set_req(1, 1'b0, 0, 7, '0);
    step();
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_vld = '0;
    pend_vld = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) step();

    // Random traffic.
    gen_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      drv_sched = ($urandom % 10) != 0;
      drv_clr   = ($urandom % 50) == 0;
      step();
    end
    gen_en = 1'b0;
    drv_sched = 1'b1;
    drv_clr = 1'b0;
    for (int guard = 0; guard < 100 && pend_vld != 0; guard++) step();
    chk("random_drain", pend_vld, 0);
    repeat (6) step();
    for (int r = 0; r < REQ_DW; r++) chk($sformatf("rsp_left[%0d]", r), rsp_q[r].size(), 0);
    for (int b = 0; b < BANK_NUM; b++) chk($sformatf("cmd_left[%0d]", b), cmd_q[b].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
